// File: rtl/rsa_job_sequencer_if.sv
// rtl/rsa_job_sequencer_if.sv - job request/response and core-side bundle for rsa_job_sequencer
//
// Purpose: groups the host request port, the response port and the RSA core
// control/data signals into one bundle.
//   slave  : the sequencer's view (accepts requests, drives the core).
//   master : the system/test view (issues requests, models the core).
// Signals:
//   req_valid/req_ready, req_p, req_q, req_mode, req_msg   job request
//   rsp_valid/rsp_ready, rsp_data, rsp_err                 job response
//   core_p, core_q, core_reset, core_start,
//   core_encrypt_decrypt, core_msg_in                      to the core
//   core_msg_out, core_finish                              from the core
interface rsa_job_sequencer_if #(
  parameter int WIDTH = 256
);
  logic             req_valid;
  logic             req_ready;
  logic [WIDTH-1:0] req_p;
  logic [WIDTH-1:0] req_q;
  logic             req_mode;
  logic [WIDTH-1:0] req_msg;

  logic             rsp_valid;
  logic             rsp_ready;
  logic [WIDTH-1:0] rsp_data;
  logic             rsp_err;

  logic [WIDTH-1:0] core_p;
  logic [WIDTH-1:0] core_q;
  logic             core_reset;
  logic             core_start;
  logic             core_encrypt_decrypt;
  logic [WIDTH-1:0] core_msg_in;
  logic [WIDTH-1:0] core_msg_out;
  logic             core_finish;

  modport slave (
    input  req_valid, req_p, req_q, req_mode, req_msg,
    output req_ready,
    output rsp_valid, rsp_data, rsp_err,
    input  rsp_ready,
    output core_p, core_q, core_reset, core_start, core_encrypt_decrypt, core_msg_in,
    input  core_msg_out, core_finish
  );

  modport master (
    output req_valid, req_p, req_q, req_mode, req_msg,
    input  req_ready,
    input  rsp_valid, rsp_data, rsp_err,
    output rsp_ready,
    input  core_p, core_q, core_reset, core_start, core_encrypt_decrypt, core_msg_in,
    output core_msg_out, core_finish
  );
endinterface

// File: rtl/rsa_job_sequencer.sv
// rtl/rsa_job_sequencer.sv - runs one RSA core encrypt/decrypt job per request
//
// Purpose: accepts a job (p, q, mode, message), pulses the core's key reset,
// waits SETUP_CYCLES for key generation, pulses the core start, waits for a
// fresh rising edge of core_finish, and returns core_msg_out on the response
// port. One job in flight at a time.
// Optional feature: define RSA_SEQ_TIMEOUT_EN to add a watchdog that aborts a
// job whose core never finishes (rsp_err = 1, rsp_data = 0).
// Ports:
//   clk    system clock, rising edge
//   reset  synchronous, active-high
//   bus    rsa_job_sequencer_if.slave (request, response and core signals)
module rsa_job_sequencer #(
  parameter int WIDTH          = 256,
  parameter int SETUP_CYCLES   = 100,
  parameter int TIMEOUT_CYCLES = 4096
) (
  input logic               clk,
  input logic               reset,
  rsa_job_sequencer_if.slave bus
);
  localparam int CNT_MAX = (SETUP_CYCLES > TIMEOUT_CYCLES) ? SETUP_CYCLES : TIMEOUT_CYCLES;
  localparam int CNT_W   = $clog2(CNT_MAX + 1);

  typedef enum logic [2:0] {
    S_IDLE, S_KRST, S_SETUP, S_START, S_WAIT, S_RESP
  } state_t;

  state_t           r_state;
  state_t           w_next;
  logic [CNT_W-1:0] r_cnt;
  logic             r_fin_armed;
  logic [WIDTH-1:0] r_p;
  logic [WIDTH-1:0] r_q;
  logic             r_mode;
  logic [WIDTH-1:0] r_msg;
  logic [WIDTH-1:0] r_rsp_data;

  logic w_fin_rise;
  logic w_timeout;
  logic w_req_ready;
  logic w_rsp_valid;
  logic w_core_reset;
  logic w_core_start;

  // A finish only counts once core_finish has been seen low inside WAIT, so a
  // level left high by the previous job cannot complete this one.
  assign w_fin_rise = (r_state == S_WAIT) && r_fin_armed && bus.core_finish;

`ifdef RSA_SEQ_TIMEOUT_EN
  logic r_rsp_err;
  // The START cycle is the watchdog's first tick, so the response lands
  // exactly TIMEOUT_CYCLES clocks after the start pulse.
  assign w_timeout   = (r_state == S_WAIT) && (r_cnt <= CNT_W'(1));
  assign bus.rsp_err = r_rsp_err;
`else
  assign w_timeout   = 1'b0;
  assign bus.rsp_err = 1'b0;
`endif

  // Next-state logic
  always_comb begin
    w_next = r_state;
    case (r_state)
      S_IDLE:  if (bus.req_valid) w_next = S_KRST;
      S_KRST:  w_next = S_SETUP;
      S_SETUP: if (r_cnt == '0) w_next = S_START;
      S_START: w_next = S_WAIT;
      S_WAIT:  if (w_fin_rise || w_timeout) w_next = S_RESP;
      S_RESP:  if (bus.rsp_ready) w_next = S_IDLE;
      default: w_next = S_IDLE;
    endcase
  end

  // State register and datapath
  always_ff @(posedge clk) begin
    if (reset) begin
      r_state     <= S_IDLE;
      r_cnt       <= '0;
      r_fin_armed <= 1'b0;
      r_p         <= '0;
      r_q         <= '0;
      r_mode      <= 1'b0;
      r_msg       <= '0;
      r_rsp_data  <= '0;
`ifdef RSA_SEQ_TIMEOUT_EN
      r_rsp_err   <= 1'b0;
`endif
    end else begin
      r_state <= w_next;
      case (r_state)
        S_IDLE: begin
          if (bus.req_valid) begin
            r_p    <= bus.req_p;
            r_q    <= bus.req_q;
            r_mode <= bus.req_mode;
            r_msg  <= bus.req_msg;
          end
        end
        S_KRST: r_cnt <= CNT_W'(SETUP_CYCLES - 1);
        S_SETUP: begin
          if (r_cnt != '0) r_cnt <= r_cnt - CNT_W'(1);
        end
        S_START: begin
          r_fin_armed <= 1'b0;
`ifdef RSA_SEQ_TIMEOUT_EN
          r_cnt       <= CNT_W'(TIMEOUT_CYCLES - 1);
`endif
        end
        S_WAIT: begin
          if (!bus.core_finish) r_fin_armed <= 1'b1;
          if (r_cnt != '0) r_cnt <= r_cnt - CNT_W'(1);
          // A finish on the watchdog's last cycle still returns the result.
          if (w_fin_rise) begin
            r_rsp_data <= bus.core_msg_out;
`ifdef RSA_SEQ_TIMEOUT_EN
            r_rsp_err  <= 1'b0;
`endif
          end else if (w_timeout) begin
            r_rsp_data <= '0;
`ifdef RSA_SEQ_TIMEOUT_EN
            r_rsp_err  <= 1'b1;
`endif
          end
        end
        default: ;
      endcase
    end
  end

  // State-decoded outputs
  always_comb begin
    w_req_ready  = 1'b0;
    w_rsp_valid  = 1'b0;
    w_core_reset = 1'b0;
    w_core_start = 1'b0;
    case (r_state)
      S_IDLE:  w_req_ready  = 1'b1;
      S_KRST:  w_core_reset = 1'b1;
      S_START: w_core_start = 1'b1;
      S_RESP:  w_rsp_valid  = 1'b1;
      default: ;
    endcase
  end

  assign bus.req_ready            = w_req_ready;
  assign bus.rsp_valid            = w_rsp_valid;
  assign bus.rsp_data             = r_rsp_data;
  assign bus.core_reset           = w_core_reset;
  assign bus.core_start           = w_core_start;
  assign bus.core_p               = r_p;
  assign bus.core_q               = r_q;
  assign bus.core_encrypt_decrypt = r_mode;
  assign bus.core_msg_in          = r_msg;
endmodule

// File: tb/tb_rsa_job_sequencer.sv
// tb/tb_rsa_job_sequencer.sv - scoreboard bench for rsa_job_sequencer with a behavioural RSA core
module tb_rsa_job_sequencer;
  localparam int WIDTH = 256;
  localparam int SETUP = 100;
  localparam int TMO   = 16;

  typedef logic [511:0] big_t;
  typedef struct {
    logic [255:0] data;
    logic         err;
  } exp_t;

  localparam logic [255:0] P  = 256'd113680897410347;
  localparam logic [255:0] Q  = 256'd7999808077935876437321;
  localparam logic [255:0] M1 = 256'h262d806a3e18f03ab37b2857e7e149;
  localparam logic [255:0] H  = 256'h48656c6c6f20576f726c6421;

  logic clk = 1'b0;
  logic reset = 1'b1;
  always #5 clk = ~clk;

  rsa_job_sequencer_if #(.WIDTH(WIDTH)) bus ();

  rsa_job_sequencer #(
    .WIDTH(WIDTH),
    .SETUP_CYCLES(SETUP),
    .TIMEOUT_CYCLES(TMO)
  ) dut (
    .clk(clk),
    .reset(reset),
    .bus(bus)
  );

  int n_checks = 0;
  int n_errors = 0;
  exp_t sb[$];

  task automatic check(input string tag, input logic [255:0] act, input logic [255:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", tag, act, exp);
    end
  endtask

  // ---------------- RSA arithmetic (behavioural core) ----------------
  function automatic big_t f_gcd(big_t a, big_t b);
    big_t t;
    while (b != 0) begin
      t = a % b;
      a = b;
      b = t;
    end
    return a;
  endfunction

  function automatic big_t f_modinv(big_t a, big_t m);
    big_t r0, r1, t0, t1, qq, tmp;
    r0 = m; r1 = a; t0 = 0; t1 = 1;
    while (r1 != 0) begin
      qq  = r0 / r1;
      tmp = r0 - qq * r1;
      r0  = r1;
      r1  = tmp;
      tmp = (t0 + m - (qq * t1) % m) % m;
      t0  = t1;
      t1  = tmp;
    end
    return t0;
  endfunction

  function automatic big_t f_modexp(big_t b, big_t x, big_t n);
    big_t r;
    r = 1;
    b = b % n;
    for (int i = 0; i < 256; i++) begin
      if (x[i]) r = (r * b) % n;
      b = (b * b) % n;
    end
    return r;
  endfunction

  function automatic logic [255:0] f_rsa(input logic [255:0] p, input logic [255:0] q,
                                         input logic enc, input logic [255:0] msg);
    big_t n, phi, e, d, r;
    n   = {256'd0, p} * {256'd0, q};
    phi = ({256'd0, p} - 1) * ({256'd0, q} - 1);
    e   = 65537;
    while (f_gcd(e, phi) != 1) e = e + 2;
    d   = f_modinv(e, phi);
    r   = enc ? f_modexp({256'd0, msg}, e, n) : f_modexp({256'd0, msg}, d, n);
    return r[255:0];
  endfunction

  // ---------------- cycle counter and pulse monitor ----------------
  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int rst_rise = 0, rst_fall = 0, rst_w = 0, st_rise = 0, st_w = 0, gap = 0;
  logic prev_rst = 1'b0, prev_st = 1'b0;
  always @(negedge clk) begin
    if (bus.core_reset && !prev_rst) rst_rise = cyc;
    if (!bus.core_reset && prev_rst) begin
      rst_fall = cyc;
      rst_w    = cyc - rst_rise;
    end
    if (bus.core_start && !prev_st) begin
      st_rise = cyc;
      gap     = cyc - rst_fall;
    end
    if (!bus.core_start && prev_st) st_w = cyc - st_rise;
    prev_rst = bus.core_reset;
    prev_st  = bus.core_start;
  end

  // ---------------- core model ----------------
  int core_delay = 8;
  int stale_hold = 0;
  bit core_dead = 1'b0;
  int fin_rise_cyc = 0;
  int m_cnt = 0, m_hold = 0;
  bit m_busy = 1'b0;
  logic [255:0] m_res;
  always @(negedge clk) begin
    if (reset) begin
      bus.core_finish  = 1'b0;
      bus.core_msg_out = '0;
      m_busy = 1'b0;
    end else if (bus.core_start) begin
      m_res  = f_rsa(bus.core_p, bus.core_q, bus.core_encrypt_decrypt, bus.core_msg_in);
      m_hold = stale_hold;
      m_cnt  = core_delay;
      m_busy = 1'b1;
      if (m_hold == 0) bus.core_finish = 1'b0;
      bus.core_msg_out = ~m_res;
    end else if (m_busy) begin
      if (m_hold > 0) begin
        m_hold--;
        if (m_hold == 0) bus.core_finish = 1'b0;
      end else if (m_cnt > 0) begin
        m_cnt--;
        if (m_cnt == 0 && !core_dead) begin
          bus.core_finish  = 1'b1;
          bus.core_msg_out = m_res;
          fin_rise_cyc     = cyc;
          m_busy           = 1'b0;
        end
      end
    end
  end

  // ---------------- request / response drivers ----------------
  logic [255:0] cur_p, cur_q, cur_msg;
  logic         cur_mode;
  int           acc_cyc = 0;

  function automatic bit core_ok();
    return (bus.core_p === cur_p) && (bus.core_q === cur_q) &&
           (bus.core_msg_in === cur_msg) && (bus.core_encrypt_decrypt === cur_mode);
  endfunction

  task automatic push_exp(input logic [255:0] d, input logic e);
    exp_t x;
    x.data = d;
    x.err  = e;
    sb.push_back(x);
  endtask

  task automatic submit(input logic [255:0] p, input logic [255:0] q,
                        input logic mode, input logic [255:0] msg);
    int n;
    cur_p = p; cur_q = q; cur_mode = mode; cur_msg = msg;
    bus.req_p = p; bus.req_q = q; bus.req_mode = mode; bus.req_msg = msg;
    bus.req_valid = 1'b1;
    n = 0;
    while (!bus.req_ready && n < 3000) begin
      @(negedge clk);
      n++;
    end
    if (!bus.req_ready) begin
      check("accept_timeout", 0, 1);
      bus.req_valid = 1'b0;
      return;
    end
    acc_cyc = cyc;
    @(negedge clk);
    bus.req_valid = 1'b0;
    bus.req_p = ~p; bus.req_q = ~q; bus.req_mode = ~mode; bus.req_msg = ~msg;
    check("req_ready_drop", bus.req_ready, 0);
  endtask

  task automatic collect(input string tag, input int bp);
    int n, bad, vcyc;
    exp_t e;
    n = 0; bad = 0;
    e.data = '0; e.err = 1'b0;
    while (!bus.rsp_valid && n < 3000) begin
      if (!core_ok()) bad++;
      @(negedge clk);
      n++;
    end
    if (!bus.rsp_valid) begin
      check({tag, "_rsp_timeout"}, 0, 1);
      return;
    end
    vcyc = cyc;
    if (sb.size() == 0) check({tag, "_sb_empty"}, 0, 1);
    else begin
      e = sb.pop_front();
      check({tag, "_data"}, bus.rsp_data, e.data);
      check({tag, "_err"}, bus.rsp_err, e.err);
    end
    check({tag, "_krst_width"}, rst_w, 1);
    check({tag, "_setup_gap"}, gap, SETUP);
    check({tag, "_start_width"}, st_w, 1);
    check({tag, "_start_offset"}, st_rise - acc_cyc, SETUP + 2);
    if (core_dead) check({tag, "_tmo_latency"}, vcyc - st_rise, TMO);
    else check({tag, "_fin_latency"}, vcyc - fin_rise_cyc, 1);
    for (int i = 0; i < bp; i++) begin
      if (bus.rsp_data !== e.data || !bus.rsp_valid || bus.req_ready) bad++;
      if (!core_ok()) bad++;
      if (i == 10) begin
        bus.req_valid = 1'b1;
        bus.req_msg   = ~cur_msg;
      end
      if (i == 11) bus.req_valid = 1'b0;
      @(negedge clk);
    end
    check({tag, "_stable"}, bad, 0);
    bus.rsp_ready = 1'b1;
    @(negedge clk);
    check({tag, "_ready_after"}, bus.req_ready, 1);
    check({tag, "_valid_after"}, bus.rsp_valid, 0);
  endtask

  task automatic check_reset_vals(input string tag);
    check({tag, "_req_ready"}, bus.req_ready, 1);
    check({tag, "_rsp_valid"}, bus.rsp_valid, 0);
    check({tag, "_rsp_data"}, bus.rsp_data, 0);
    check({tag, "_rsp_err"}, bus.rsp_err, 0);
    check({tag, "_core_reset"}, bus.core_reset, 0);
    check({tag, "_core_start"}, bus.core_start, 0);
    check({tag, "_core_p"}, bus.core_p, 0);
    check({tag, "_core_q"}, bus.core_q, 0);
    check({tag, "_core_msg_in"}, bus.core_msg_in, 0);
    check({tag, "_core_mode"}, bus.core_encrypt_decrypt, 0);
  endtask

  initial begin
    #2000000;
    $display("FAIL global_timeout: simulation did not complete");
    $fatal(1);
  end

  initial begin
    logic [255:0] e1, c2;
    int n, seen;
    bus.req_valid = 1'b0;
    bus.req_p = '0; bus.req_q = '0; bus.req_mode = 1'b0; bus.req_msg = '0;
    bus.rsp_ready = 1'b1;
    cur_p = '0; cur_q = '0; cur_mode = 1'b0; cur_msg = '0;

    repeat (3) @(negedge clk);
    check_reset_vals("por");
    reset = 1'b0;
    @(negedge clk);

    e1 = f_rsa(P, Q, 1'b0, M1);
    c2 = f_rsa(P, Q, 1'b1, H);

    // decrypt job
    push_exp(e1, 1'b0); submit(P, Q, 1'b0, M1); collect("dec1", 0);
    // encrypt jobs and round trips
    push_exp(c2, 1'b0); submit(P, Q, 1'b1, H);  collect("enc_hello", 0);
    push_exp(H, 1'b0);  submit(P, Q, 1'b0, c2); collect("dec_hello", 0);
    push_exp(M1, 1'b0); submit(P, Q, 1'b1, e1); collect("enc_rt", 0);

    // response backpressure with a stray request while pending
    bus.rsp_ready = 1'b0;
    push_exp(c2, 1'b0); submit(P, Q, 1'b1, H); collect("bp", 50);

    // finish left high from the previous job
    stale_hold = 4;
    push_exp(e1, 1'b0); submit(P, Q, 1'b0, M1); collect("stale", 0);
    stale_hold = 0;

    // reset in the middle of WAIT
    submit(P, Q, 1'b1, H);
    n = 0;
    while (!bus.core_start && n < 3000) begin
      @(negedge clk);
      n++;
    end
    check("midrst_saw_start", bus.core_start, 1);
    repeat (3) @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    check_reset_vals("midrst");
    reset = 1'b0;
    cur_p = '0; cur_q = '0; cur_mode = 1'b0; cur_msg = '0;
    seen = 0;
    for (int i = 0; i < 30; i++) begin
      @(negedge clk);
      if (bus.rsp_valid) seen++;
    end
    check("midrst_no_rsp", seen, 0);
    push_exp(e1, 1'b0); submit(P, Q, 1'b0, M1); collect("after_rst", 0);

`ifdef RSA_SEQ_TIMEOUT_EN
    core_dead = 1'b1;
    push_exp('0, 1'b1); submit(P, Q, 1'b0, M1); collect("timeout", 0);
    core_dead = 1'b0;
    push_exp(e1, 1'b0); submit(P, Q, 1'b0, M1); collect("after_tmo", 0);
`endif

    check("sb_drained", sb.size(), 0);
    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end
endmodule
